// File: rtl/wb_dma_pkg.sv
// ----------------------------------------------------------------------------
// wb_dma_pkg
// Shared definitions for the fir_DMA memory-side Wishbone responder:
//   - responder FSM state encoding
//   - default window base address and Wishbone data/select widths
//   - latched request record
//   - XADDR/YADDR buffer addresses shared with fir_DMA
// No ports (package).
// ----------------------------------------------------------------------------
package wb_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3800_0000;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = WB_DAT_W / 8;

  // Input-sample (X) and output-result (Y) buffers used by fir_DMA.
  localparam logic [31:0] XADDR = 32'h3800_0000;
  localparam logic [31:0] YADDR = 32'h3800_0800;

  // Everything the responder needs from the request, captured on acceptance
  // so the master may change its outputs while the access is in flight.
  typedef struct packed {
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [31:0]         adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_dma_mem_array.sv
// ----------------------------------------------------------------------------
// wb_dma_mem_array
// Single-port 32-bit RAM with per-byte write enables and a registered read
// port. Contents are not reset.
// Ports:
//   clk_i      clock
//   we_i       byte-lane write enables (bit n writes wdata_i[8n+7:8n])
//   re_i       read enable; rdata_o updates on the following edge
//   addr_i     word index
//   wdata_i    write data
//   rdata_o    registered read data
// ----------------------------------------------------------------------------
module wb_dma_mem_array
  import wb_dma_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk_i,
  input  logic [WB_SEL_W-1:0] we_i,
  input  logic                re_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic [WB_DAT_W-1:0] rdata_o
);

  logic [WB_DAT_W-1:0] mem_q [DEPTH_WORDS];
  logic [WB_DAT_W-1:0] rdata_q;

  // NOTE: the storage array and its read register carry no reset so they map
  // onto RAM macros; reset only makes sense for control state.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_dma_mem_responder.sv
// ----------------------------------------------------------------------------
// wb_dma_mem_responder
// Wishbone classic slave acting as the SDRAM-side memory behind fir_DMA.
// A request is latched in IDLE, held for a fixed LATENCY, then answered with
// exactly one ack (or err) cycle. Byte-lane writes and reads are performed on
// the edge that enters the response cycle.
//
// Parameters:
//   BASE_ADDR    byte address of word 0 of the window
//   DEPTH_WORDS  window size in 32-bit words (power of two)
//   LATENCY      edges from acceptance to the edge that raises ack (1..255)
//
// Optional feature (compile-time macro WB_DMA_RESP_RANGE_ERR_EN):
//   defined   - out-of-window or misaligned requests complete with err
//               after the same latency; no memory or counter update
//   undefined - wbs_err_o is 0, the word index wraps and adr[1:0] is ignored
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_stb_i, wbs_cyc_i      request strobe / cycle
//   wbs_we_i, wbs_sel_i       write flag, byte enables
//   wbs_dat_i, wbs_adr_i      write data, byte address
//   wbs_ack_o, wbs_err_o      one-cycle completion / error pulses
//   wbs_dat_o                 read data while ack is high, otherwise 0
//   rd_cnt_o, wr_cnt_o        completed read / write counts (wrapping)
// ----------------------------------------------------------------------------
module wb_dma_mem_responder
  import wb_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 10
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [WB_SEL_W-1:0] wbs_sel_i,
  input  logic [WB_DAT_W-1:0] wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic                wbs_err_o,
  output logic [WB_DAT_W-1:0] wbs_dat_o,
  output logic [15:0]         rd_cnt_o,
  output logic [15:0]         wr_cnt_o
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  state_e              state_q;
  wb_req_t             req_q;
  logic [7:0]          cnt_q;
  logic                ack_q;
  logic                err_q;
  logic                rd_vld_q;
  logic [15:0]         rd_cnt_q;
  logic [15:0]         wr_cnt_q;
  logic [15:0]         rd_cnt_d;
  logic [15:0]         wr_cnt_d;

  logic                accept_w;
  logic                finish_w;
  logic                range_err_w;
  logic [31:0]         off_w;
  logic [AW-1:0]       idx_w;
  logic [WB_SEL_W-1:0] mem_we_w;
  logic                mem_re_w;
  logic [WB_DAT_W-1:0] mem_rdata_w;
  logic                unused_off;

  // Requests are only sampled in IDLE, which also yields the one-cycle gap
  // after RESP when the master keeps stb/cyc asserted.
  assign accept_w = (state_q == ST_IDLE) && wbs_stb_i && wbs_cyc_i;

  // Completion edge; an edge with cyc low in BUSY aborts instead.
  assign finish_w = (state_q == ST_BUSY) && wbs_cyc_i && (cnt_q == 8'd0);

  // Offset from the window base; wraps naturally below BASE_ADDR.
  assign off_w = req_q.adr - BASE_ADDR;
  assign idx_w = off_w[AW+1:2];

`ifdef WB_DMA_RESP_RANGE_ERR_EN
  // Any offset bit above the window, or a sub-word address, is an error.
  assign range_err_w = (off_w[31:AW+2] != '0) || (req_q.adr[1:0] != 2'b00);
`else
  assign range_err_w = 1'b0;
`endif

  // Upper offset bits only matter for the range check; the byte-offset bits
  // never select anything.
  assign unused_off = ^{off_w[31:AW+2], off_w[1:0]};

  // Memory is touched on the same edge that enters RESP.
  assign mem_we_w = (finish_w && !range_err_w && req_q.we) ? req_q.sel : '0;
  assign mem_re_w = finish_w && !range_err_w && !req_q.we;

  assign rd_cnt_d = rd_cnt_q + 16'd1;
  assign wr_cnt_d = wr_cnt_q + 16'd1;

  wb_dma_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk_i   (wb_clk_i),
    .we_i    (mem_we_w),
    .re_i    (mem_re_w),
    .addr_i  (idx_w),
    .wdata_i (req_q.dat),
    .rdata_o (mem_rdata_w)
  );

  // LATENCY=1 loads a zero count, so the single BUSY edge enters RESP and the
  // ack still lands LATENCY edges after acceptance.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      cnt_q    <= 8'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            req_q   <= '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};
            cnt_q   <= CNT_INIT;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!wbs_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == 8'd0) begin
            state_q <= ST_RESP;
            if (range_err_w) begin
              err_q <= 1'b1;
            end else begin
              ack_q <= 1'b1;
              if (req_q.we) begin
                wr_cnt_q <= wr_cnt_d;
              end else begin
                rd_cnt_q <= rd_cnt_d;
                rd_vld_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  // The RAM read register has no reset, so the output is gated by a flag that
  // does; this also forces 0 outside the read response cycle.
  assign wbs_dat_o = rd_vld_q ? mem_rdata_w : '0;
  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;

endmodule

// File: tb/tb_wb_dma_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_wb_dma_mem_responder
// Self-checking bench: a driver issues requests and pushes the expected
// response into a scoreboard queue; a monitor pops and compares on every
// ack/err. Expected data comes from a word-array model of the window.
// Honours WB_DMA_RESP_RANGE_ERR_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_wb_dma_mem_responder;

  localparam logic [31:0] BASE  = 32'h3800_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 10;

  logic        clk;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack, err;
  logic [31:0] dat_o;
  logic [15:0] rd_cnt, wr_cnt;

  wb_dma_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_err_o (err),
    .wbs_dat_o (dat_o),
    .rd_cnt_o  (rd_cnt),
    .wr_cnt_o  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          done_cnt = 0;
  int          earliest_accept = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference model: window arithmetic straight from the address map.
  function automatic bit model_err(input logic [31:0] a);
`ifdef WB_DMA_RESP_RANGE_ERR_EN
    longint unsigned la = longint'(a);
    longint unsigned lb = longint'(BASE);
    return (la < lb) || (la >= lb + 4 * DEPTH) || (a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'((d / 4) % DEPTH);
  endfunction

  // Monitor: every ack/err consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ack || err) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got ack=%0b err=%0b, expected none pending (cycle %0d)",
                   ack, err, cyc_cnt);
        end else begin
          e = sb_q.pop_front();
          check("resp_kind", {30'd0, ack, err}, e.is_err ? 32'd1 : 32'd2);
          check("resp_cycle", cyc_cnt, e.cyc);
          if (e.is_rd || e.is_err) check("rd_data", dat_o, e.data);
          if (!e.is_err) begin
            if (e.is_rd) exp_rd++;
            else         exp_wr++;
          end
          check("rd_cnt", {16'd0, rd_cnt}, {16'd0, exp_rd[15:0]});
          check("wr_cnt", {16'd0, wr_cnt}, {16'd0, exp_wr[15:0]});
        end
        earliest_accept = cyc_cnt + 2;
        done_cnt++;
      end else begin
        check("dat_idle_zero", dat_o, 32'h0);
      end
    end
  end

  // One complete transfer. Called at negedge+1; returns at negedge+1 with the
  // bus either still requesting (gap=0) or idle after `gap` cycles.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int gap);
    exp_t e;
    int   acc, idx, d0, waited;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    acc      = (cyc_cnt + 1 > earliest_accept) ? cyc_cnt + 1 : earliest_accept;
    idx      = model_idx(a);
    e.is_err = model_err(a);
    e.is_rd  = !w;
    e.cyc    = acc + LAT;
    e.data   = (e.is_err || w) ? 32'h0 : model_mem[idx];
    if (w && !e.is_err) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
    sb_q.push_back(e);
    d0 = done_cnt;
    waited = 0;
    while (done_cnt == d0 && waited < LAT + 20) begin
      @(negedge clk); #1;
      waited++;
      // Fields are latched; scramble them while the access is in flight.
      if (done_cnt == d0 && cyc_cnt == acc) begin
        we = 1'($urandom); adr = $urandom; sel = 4'($urandom); dat_i = $urandom;
      end
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no response for adr %h, expected one by cycle %0d", a, e.cyc);
      sb_q.delete();
    end
    if (gap > 0) begin
      cyc = 1'b0;
      stb = 1'($urandom);  // stb without cyc must be ignored
      repeat (gap) begin @(negedge clk); #1; end
      stb = 1'b0;
    end
  endtask

  task automatic abort_test(input int idx);
    int acc;
    logic [31:0] a;
    a = BASE + 32'(4 * idx);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 4'hF; dat_i = 32'hBAD0_BAD0;
    acc = (cyc_cnt + 1 > earliest_accept) ? cyc_cnt + 1 : earliest_accept;
    while (cyc_cnt < acc + 4) begin @(negedge clk); #1; end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); #1;
    check("abort_wr_cnt", {16'd0, wr_cnt}, {16'd0, exp_wr[15:0]});
    check("abort_no_ack", {31'd0, ack}, 32'd0);
    // Back in IDLE: the very next edge must accept.
    earliest_accept = 0;
    xfer(1'b0, a, 4'hF, 32'h0, 1);
  endtask

  task automatic reset_midop_test(input int idx);
    int acc;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'(4 * idx); sel = 4'hF;
    acc = (cyc_cnt + 1 > earliest_accept) ? cyc_cnt + 1 : earliest_accept;
    while (cyc_cnt < acc + 3) begin @(negedge clk); #1; end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    check("rst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    earliest_accept = 0;
    xfer(1'b0, BASE + 32'(4 * idx), 4'hF, 32'h0, 1);
  endtask

  initial begin
    int          idx, r;
    logic [31:0] a;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0; adr = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_dat", dat_o, 32'h0);
    check("reset_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    check("reset_wr_cnt", {16'd0, wr_cnt}, 32'd0);
    #1 rst = 1'b0;

    // Write then read back.
    xfer(1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 1);
    xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 1);

    // Preload words 0..63.
    for (int k = 0; k < 64; k++)
      xfer(1'b1, BASE + 32'(4 * k), 4'hF, $urandom, $urandom_range(0, 2));

    // Byte-lane merge.
    xfer(1'b1, 32'h3800_0014, 4'hF, 32'h1122_3344, 1);
    xfer(1'b1, 32'h3800_0014, 4'b0101, 32'hAABB_CCDD, 1);
    xfer(1'b0, 32'h3800_0014, 4'hF, 32'h0, 1);

    // DMA-like burst with a one-cycle stb drop after each ack.
    for (int k = 0; k < 64; k++)
      xfer(1'b0, BASE + 32'(4 * k), 4'hF, $urandom, 1);

    // Random mix, including wrapped / misaligned addresses.
    for (int n = 0; n < 80; n++) begin
      r   = $urandom_range(0, 7);
      idx = $urandom_range(0, 63);
      case (r)
        0:       a = BASE + 32'(4 * (DEPTH + idx));
        1:       a = BASE - 32'(4 * (DEPTH - idx));
        2:       a = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
        default: a = BASE + 32'(4 * idx);
      endcase
      xfer(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 2));
    end

    abort_test(7);
    reset_midop_test(9);

    // First word past the window: err with the feature, wraps to word 0 without.
    xfer(1'b0, 32'h3800_1000, 4'hF, 32'h0, 1);
    xfer(1'b0, 32'h3800_0002, 4'hF, 32'h0, 1);

    cyc = 1'b0; stb = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    check("final_rd_cnt", {16'd0, rd_cnt}, {16'd0, exp_rd[15:0]});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
